// File: rtl/regs_wb.sv
// regs_wb: write-back stage and sole writer of the register file.
// Merges ex results with long-latency results and tracks pending writes.
module regs_wb #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int LT_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_we_i,
    input  logic [ADDR_W-1:0]   ex_waddr_i,
    input  logic [DATA_W-1:0]   ex_wdata_i,
    input  logic                lt_issue_i,
    input  logic [ADDR_W-1:0]   lt_issue_addr_i,
    input  logic                lt_valid_i,
    input  logic [ADDR_W-1:0]   lt_addr_i,
    input  logic [DATA_W-1:0]   lt_data_i,
    output logic                lt_ready_o,
    input  logic [ADDR_W-1:0]   id_raddr1_i,
    input  logic [ADDR_W-1:0]   id_raddr2_i,
    input  logic                id_we_i,
    input  logic [ADDR_W-1:0]   id_waddr_i,
    output logic                stall_o,
    output logic                reg_we_o,
    output logic [ADDR_W-1:0]   reg_waddr_o,
    output logic [DATA_W-1:0]   reg_wdata_o,
    output logic [NUM_REGS-1:0] busy_o
);

    localparam int PTR_W = $clog2(LT_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    logic [ADDR_W-1:0]   fifo_addr [LT_DEPTH];
    logic [DATA_W-1:0]   fifo_data [LT_DEPTH];
    logic [PTR_W-1:0]    wptr;
    logic [PTR_W-1:0]    rptr;
    logic [NUM_REGS-1:0] busy_q;

    logic                full;
    logic                empty;
    logic                ex_sel;
    logic                pop;
    logic                bypass;
    logic                accept;
    logic                push;
    logic                lt_write;
    logic                sel_valid;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                   (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);

    assign ex_sel = ex_we_i && (ex_waddr_i != '0);

    // Pick this cycle's write source: ex, then queued lt, then lt bypass
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        pop       = 1'b0;
        bypass    = 1'b0;
        lt_write  = 1'b0;
        if (ex_sel) begin
            sel_valid = 1'b1;
            sel_addr  = ex_waddr_i;
            sel_data  = ex_wdata_i;
        end else if (!empty) begin
            sel_valid = 1'b1;
            pop       = 1'b1;
            lt_write  = 1'b1;
            sel_addr  = fifo_addr[rptr[IDX_W-1:0]];
            sel_data  = fifo_data[rptr[IDX_W-1:0]];
        end else if (lt_valid_i) begin
            sel_valid = 1'b1;
            bypass    = 1'b1;
            lt_write  = 1'b1;
            sel_addr  = lt_addr_i;
            sel_data  = lt_data_i;
        end
    end

    // Ready is from pre-pop state; x0 results are consumed, never queued
    assign lt_ready_o = ~full;
    assign accept     = lt_valid_i & ~full;
    assign push       = accept & ~bypass & (lt_addr_i != '0);

    assign stall_o = busy_q[id_raddr1_i] |
                     busy_q[id_raddr2_i] |
                     (id_we_i & busy_q[id_waddr_i]);

    // Scoreboard set/clear requests for this edge
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (lt_issue_i && !stall_o && (lt_issue_addr_i != '0))
            set_mask[lt_issue_addr_i] = 1'b1;
        if (lt_write && (sel_addr != '0))
            clr_mask[sel_addr] = 1'b1;
    end

    // Busy scoreboard; a set beats a clear of the same register
    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= (busy_q & ~clr_mask) | set_mask;
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    // FIFO storage; contents are meaningless while empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wptr[IDX_W-1:0]] <= lt_addr_i;
            fifo_data[wptr[IDX_W-1:0]] <= lt_data_i;
        end
    end

    // Register the selected write toward the register file
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
        end else begin
            reg_we_o    <= sel_valid && (sel_addr != '0);
            reg_waddr_o <= sel_addr;
            reg_wdata_o <= sel_data;
        end
    end

    assign busy_o = busy_q;

endmodule
